// File: rtl/sa_wb_fifo.sv
// Write-back FIFO between the systolic-array output and the shared SRAM port.
// Buffers {addr,row} pushes, drains them in order under req/gnt, and pulses flush_done at job end.
module sa_wb_fifo #(
    parameter int unsigned N        = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 13,
    parameter int unsigned AFULL_TH = DEPTH - 4,
    localparam int unsigned DW      = N * 8,
    localparam int unsigned LW      = $clog2(DEPTH + 1),
    localparam int unsigned PW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen_n,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] data_in,
    input  logic          done_all,
    input  logic          clr_ovf,
    output logic          sram_req,
    input  logic          sram_gnt,
    output logic          sram_wen_n,
    output logic [AW-1:0] sram_waddr,
    output logic [DW-1:0] sram_wdata,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          full,
    output logic          overflow,
    output logic          flush_done
);

    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             flush_q;
    state_e           state_q;

    logic             push_req, push_ok, pop, is_full;
    logic [AW+DW-1:0] head;

    assign is_full  = (level_q == LW'(DEPTH));
    assign push_req = !wen_n;
    assign pop      = sram_req && sram_gnt;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push_req && (!is_full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(push_ok) - LW'(pop);
        // Set beats clear when both happen together.
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {waddr, data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (done_all || state_q == StDrain) begin
                // level_d already includes any push of this cycle.
                if (level_d == '0) begin
                    flush_q <= 1'b1;
                    state_q <= StIdle;
                end else begin
                    state_q <= StDrain;
                end
            end else if (state_q == StIdle && push_ok) begin
                state_q <= StActive;
            end
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign sram_req    = (level_q != '0);
    assign sram_wen_n  = !pop;
    assign sram_waddr  = sram_req ? head[AW+DW-1:DW] : '0;
    assign sram_wdata  = sram_req ? head[DW-1:0] : '0;
    assign level       = level_q;
    assign almost_full = (level_q >= LW'(AFULL_TH));
    assign full        = is_full;
    assign overflow    = ovf_q;
    assign flush_done  = flush_q;

endmodule

// File: tb/tb_sa_wb_fifo.sv
// Randomized and directed bench for sa_wb_fifo against a queue-based reference model.
module tb_sa_wb_fifo;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = N * 8;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    typedef logic [AW+DW-1:0] entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wen_n;
    logic [AW-1:0] waddr;
    logic [DW-1:0] data_in;
    logic          done_all;
    logic          clr_ovf;
    logic          sram_req;
    logic          sram_gnt;
    logic          sram_wen_n;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          full;
    logic          overflow;
    logic          flush_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    entry_t        m_q[$];
    bit            m_ovf;
    bit            m_draining;
    bit            m_flush;

    int            strobes;
    int            flushes;
    logic [AW-1:0] seen_addr[$];

    always #5 clk = ~clk;

    sa_wb_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wen_n       (wen_n),
        .waddr       (waddr),
        .data_in     (data_in),
        .done_all    (done_all),
        .clr_ovf     (clr_ovf),
        .sram_req    (sram_req),
        .sram_gnt    (sram_gnt),
        .sram_wen_n  (sram_wen_n),
        .sram_waddr  (sram_waddr),
        .sram_wdata  (sram_wdata),
        .level       (level),
        .almost_full (almost_full),
        .full        (full),
        .overflow    (overflow),
        .flush_done  (flush_done)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 1'b0;
        m_draining = 1'b0;
        m_flush    = 1'b0;
    endtask

    task automatic idle_inputs();
        wen_n    = 1'b1;
        waddr    = '0;
        data_in  = '0;
        done_all = 1'b0;
        clr_ovf  = 1'b0;
        sram_gnt = 1'b0;
    endtask

    // One clock: check outputs at the negedge, advance the model, return just after posedge.
    task automatic tick();
        bit     do_pop;
        entry_t head;
        int     sz;
        @(negedge clk);
        sz     = m_q.size();
        do_pop = (sz != 0) && sram_gnt;
        head   = (sz != 0) ? m_q[0] : '0;
        check_eq("level", level, sz);
        check_eq("full", full, sz == DEPTH);
        check_eq("almost_full", almost_full, sz >= DEPTH - 4);
        check_eq("overflow", overflow, m_ovf);
        check_eq("flush_done", flush_done, m_flush);
        check_eq("sram_req", sram_req, sz != 0);
        check_eq("sram_wen_n", sram_wen_n, !do_pop);
        check_eq("sram_waddr", sram_waddr, head[AW+DW-1:DW]);
        check_eq("sram_wdata", sram_wdata, head[DW-1:0]);
        if (!sram_wen_n) begin
            strobes++;
            seen_addr.push_back(sram_waddr);
        end
        if (flush_done) flushes++;

        if (do_pop) void'(m_q.pop_front());
        if (!wen_n) begin
            if (sz < DEPTH || do_pop) m_q.push_back({waddr, data_in});
            else m_ovf = 1'b1;
        end else if (clr_ovf) begin
            m_ovf = 1'b0;
        end
        if (!wen_n && sz == DEPTH && !do_pop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        m_flush = 1'b0;
        if (done_all || m_draining) begin
            if (m_q.size() == 0) begin
                m_flush    = 1'b1;
                m_draining = 1'b0;
            end else begin
                m_draining = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic g);
        wen_n    = 1'b0;
        waddr    = a;
        data_in  = d;
        sram_gnt = g;
        tick();
        wen_n    = 1'b1;
    endtask

    task automatic clear_counts();
        strobes = 0;
        flushes = 0;
        seen_addr.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", sram_req, 1'b0);
        check_eq("rst_wen_n", sram_wen_n, 1'b1);
        check_eq("rst_level", level, 0);
        check_eq("rst_waddr", sram_waddr, 0);
        rst_n = 1'b1;

        // Three rows drained with grant held high
        clear_counts();
        for (int i = 0; i < 3; i++) push(AW'(13'h010 + i), 64'h0102030405060708 + DW'(i), 1'b1);
        repeat (3) tick();
        check_eq("t1_strobes", strobes, 3);
        check_eq("t1_order", {seen_addr[0], seen_addr[1], seen_addr[2]},
                 {13'h010, 13'h011, 13'h012});
        check_eq("t1_level", level, 0);

        // Fill without grant, then overflow, then clear
        for (int i = 0; i < 16; i++) push(AW'(13'h100 + i), DW'($urandom) << 32 | DW'($urandom), 1'b0);
        check_eq("t2_full", full, 1'b1);
        push(13'h1EE, 64'hDEAD, 1'b0);
        check_eq("t2_ovf", overflow, 1'b1);
        check_eq("t2_level", level, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("t2_ovf_clr", overflow, 1'b0);

        // Push and pop together while full
        clear_counts();
        push(13'h1FF, 64'hCAFE, 1'b1);
        check_eq("t3_level", level, 16);
        check_eq("t3_ovf", overflow, 1'b0);
        sram_gnt = 1'b1;
        repeat (17) tick();
        check_eq("t3_strobes", strobes, 17);
        check_eq("t3_last", seen_addr[16], 13'h1FF);

        // Flush after done_all with delayed grant
        clear_counts();
        for (int i = 0; i < 5; i++) push(AW'(13'h200 + i), DW'(i * 3), 1'b0);
        done_all = 1'b1;
        tick();
        done_all = 1'b0;
        repeat (3) tick();
        check_eq("t4_no_early_flush", flushes, 0);
        sram_gnt = 1'b1;
        repeat (8) tick();
        check_eq("t4_flushes", flushes, 1);
        check_eq("t4_strobes", strobes, 5);

        // Alternating grant holds head stable
        clear_counts();
        for (int i = 0; i < 4; i++) push(AW'(13'h300 + i), DW'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) begin
            sram_gnt = (i % 2 == 0);
            tick();
        end
        check_eq("t5_strobes", strobes, 4);

        // Reset during drain
        clear_counts();
        for (int i = 0; i < 6; i++) push(AW'(13'h400 + i), DW'(i), 1'b0);
        done_all = 1'b1;
        tick();
        done_all = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_req", sram_req, 1'b0);
        check_eq("t6_level", level, 0);
        check_eq("t6_flush", flush_done, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("t6_no_flush", flushes, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            wen_n    = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
            waddr    = AW'($urandom);
            data_in  = {$urandom, $urandom};
            sram_gnt = ($urandom_range(0, 99) < 45);
            done_all = ($urandom_range(0, 99) < 3);
            clr_ovf  = ($urandom_range(0, 99) < 5);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
